// File: rtl/clkdiv_display_compare.sv
// clkdiv_display_compare: square-wave divider, streaming fp32 argmax and HEX/LED display driver
module clkdiv_display_compare #(
   parameter int HALF_PERIOD = 25_000_000,
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   output logic             clk_out,
   input  logic             cmp_start,
   input  logic [31:0]      cmp_data,
   input  logic [IDX_W-1:0] cmp_index_in,
   output logic [IDX_W-1:0] cmp_index_out,
   output logic [31:0]      cmp_max,
   input  logic [7:0]       in1,
   input  logic [7:0]       in2,
   input  logic [7:0]       in3,
   input  logic [7:0]       in4,
   output logic [7:0]       seg1,
   output logic [7:0]       seg2,
   output logic [7:0]       seg3,
   output logic [7:0]       seg4,
   output logic [7:0]       seg5,
   output logic [7:0]       seg6,
   output logic [7:0]       ledr
);
   localparam int CW = HALF_PERIOD > 1 ? $clog2(HALF_PERIOD) : 1;
   localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);
   localparam logic [7:0] HEX [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
   };
   logic [CW-1:0] cnt;
   logic a_nan, b_nan, both_zero, gt;
   // Divider: wrap the counter every HALF_PERIOD cycles and toggle the output
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         cnt <= '0;
         clk_out <= 1'b0;
      end else if (cnt == LAST) begin
         cnt <= '0;
         clk_out <= ~clk_out;
      end else
         cnt <= cnt + 1'b1;
   // Strict fp32 greater-than of the incoming score against the running max; NaN never wins
   always_comb begin
      a_nan = &cmp_data[30:23] && |cmp_data[22:0];
      b_nan = &cmp_max[30:23] && |cmp_max[22:0];
      both_zero = ~|cmp_data[30:0] && ~|cmp_max[30:0];
      gt = (a_nan || b_nan) ? 1'b0 :
           (cmp_data[31] != cmp_max[31]) ? (!cmp_data[31] && !both_zero) :
           !cmp_data[31] ? (cmp_data[30:0] > cmp_max[30:0]) :
           (cmp_data[30:0] < cmp_max[30:0]);
   end
   // Comparator: index 0 reloads unconditionally, later indices replace only a strictly smaller max
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         cmp_max <= 32'hFF80_0000;
         cmp_index_out <= '0;
      end else if (cmp_start && (cmp_index_in == '0 || gt)) begin
         cmp_max <= cmp_data;
         cmp_index_out <= cmp_index_in;
      end
   // Display: register the active-low digit patterns and the LED bar
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         seg1 <= 8'hFF;
         seg2 <= 8'hFF;
         seg3 <= 8'hFF;
         seg4 <= 8'hFF;
         seg5 <= 8'hFF;
         seg6 <= 8'hFF;
         ledr <= 8'h00;
      end else begin
         seg1 <= HEX[in1[3:0]];
         seg2 <= HEX[in1[7:4]];
         seg3 <= HEX[in2[3:0]];
         seg4 <= HEX[in2[7:4]];
         seg5 <= HEX[in3[3:0]];
         seg6 <= HEX[in3[7:4]];
         ledr <= in4;
      end
endmodule

// File: tb/tb_clkdiv_display_compare.sv
// tb_clkdiv_display_compare: scoreboard bench for divider, argmax and display
module tb_clkdiv_display_compare;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic clk_out;
   logic cmp_start = 1'b0;
   logic [31:0] cmp_data = '0;
   logic [3:0] cmp_index_in = '0;
   logic [3:0] cmp_index_out;
   logic [31:0] cmp_max;
   logic [7:0] in1 = '0, in2 = '0, in3 = '0, in4 = '0;
   logic [7:0] seg1, seg2, seg3, seg4, seg5, seg6, ledr;

   clkdiv_display_compare #(.HALF_PERIOD(4), .IDX_W(4)) dut (
      .clk(clk), .reset_n(reset_n), .clk_out(clk_out),
      .cmp_start(cmp_start), .cmp_data(cmp_data), .cmp_index_in(cmp_index_in),
      .cmp_index_out(cmp_index_out), .cmp_max(cmp_max),
      .in1(in1), .in2(in2), .in3(in3), .in4(in4),
      .seg1(seg1), .seg2(seg2), .seg3(seg3), .seg4(seg4), .seg5(seg5), .seg6(seg6),
      .ledr(ledr)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int due; int kind; logic [31:0] exp; } exp_t;
   typedef struct { logic st; logic [3:0] idx; logic [31:0] d; logic [3:0] e_idx; logic [31:0] e_max; } cv_t;

   exp_t q[$];
   int checks = 0;
   int failures = 0;

   function automatic logic [31:0] actual(input int k);
      case (k)
         0: return {31'b0, clk_out};
         1: return cmp_max;
         2: return {28'b0, cmp_index_out};
         3: return {24'b0, seg1};
         4: return {24'b0, seg2};
         5: return {24'b0, seg3};
         6: return {24'b0, seg4};
         7: return {24'b0, seg5};
         8: return {24'b0, seg6};
         default: return {24'b0, ledr};
      endcase
   endfunction

   function automatic string nm(input int k);
      case (k)
         0: return "clk_out";
         1: return "cmp_max";
         2: return "cmp_index_out";
         3: return "seg1";
         4: return "seg2";
         5: return "seg3";
         6: return "seg4";
         7: return "seg5";
         8: return "seg6";
         default: return "ledr";
      endcase
   endfunction

   // Monitor: compare every expectation that has come due against the live outputs
   exp_t mon_e;
   logic [31:0] mon_a;
   always @(negedge clk)
      while (q.size() > 0 && q[0].due <= cyc) begin
         mon_e = q.pop_front();
         mon_a = actual(mon_e.kind);
         checks++;
         if (mon_a !== mon_e.exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", nm(mon_e.kind), cyc, mon_a, mon_e.exp);
         end
      end

   task automatic expect_v(input int kind, input logic [31:0] v, input int lat);
      q.push_back('{cyc + lat, kind, v});
   endtask

   task automatic expect_reset();
      expect_v(0, 32'h0, 0);
      expect_v(1, 32'hFF80_0000, 0);
      expect_v(2, 32'h0, 0);
      for (int i = 3; i <= 8; i++) expect_v(i, 32'hFF, 0);
      expect_v(9, 32'h00, 0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      tick();
      cmp_start = 1'b0;
   endtask

   task automatic disp(input logic [7:0] a, b, c, d, input logic [47:0] segs);
      tick();
      in1 = a; in2 = b; in3 = c; in4 = d;
      for (int i = 0; i < 6; i++) expect_v(3 + i, {24'b0, segs[47 - 8*i -: 8]}, 1);
      expect_v(9, {24'b0, d}, 1);
   endtask

   task automatic cmp(input cv_t v);
      tick();
      cmp_start = v.st;
      cmp_index_in = v.idx;
      cmp_data = v.d;
      expect_v(1, v.e_max, 1);
      expect_v(2, {28'b0, v.e_idx}, 1);
   endtask

   cv_t pos_v[10];
   cv_t neg_v[9];
   cv_t gate_v[5];

   initial begin
      pos_v = '{
         '{1'b1, 4'd0, 32'h3F80_0000, 4'd0, 32'h3F80_0000},
         '{1'b1, 4'd1, 32'h4020_0000, 4'd1, 32'h4020_0000},
         '{1'b1, 4'd2, 32'h3F00_0000, 4'd1, 32'h4020_0000},
         '{1'b1, 4'd3, 32'h4020_0000, 4'd1, 32'h4020_0000},
         '{1'b1, 4'd4, 32'h40E0_0000, 4'd4, 32'h40E0_0000},
         '{1'b1, 4'd5, 32'h4040_0000, 4'd4, 32'h40E0_0000},
         '{1'b1, 4'd6, 32'h3FC0_0000, 4'd4, 32'h40E0_0000},
         '{1'b1, 4'd7, 32'h40D0_0000, 4'd4, 32'h40E0_0000},
         '{1'b1, 4'd8, 32'hBF80_0000, 4'd4, 32'h40E0_0000},
         '{1'b1, 4'd9, 32'h40E0_0000, 4'd4, 32'h40E0_0000}
      };
      neg_v = '{
         '{1'b1, 4'd0, 32'hC040_0000, 4'd0, 32'hC040_0000},
         '{1'b1, 4'd1, 32'hBF80_0000, 4'd1, 32'hBF80_0000},
         '{1'b1, 4'd2, 32'h7FC0_0000, 4'd1, 32'hBF80_0000},
         '{1'b1, 4'd3, 32'h8000_0000, 4'd3, 32'h8000_0000},
         '{1'b1, 4'd4, 32'h0000_0000, 4'd3, 32'h8000_0000},
         '{1'b1, 4'd0, 32'hC0A0_0000, 4'd0, 32'hC0A0_0000},
         '{1'b1, 4'd1, 32'h7F80_0000, 4'd1, 32'h7F80_0000},
         '{1'b1, 4'd2, 32'h7FC0_0000, 4'd1, 32'h7F80_0000},
         '{1'b1, 4'd3, 32'hFF80_0000, 4'd1, 32'h7F80_0000}
      };
      gate_v = '{
         '{1'b1, 4'd0, 32'h4000_0000, 4'd0, 32'h4000_0000},
         '{1'b0, 4'd1, 32'h4100_0000, 4'd0, 32'h4000_0000},
         '{1'b1, 4'd2, 32'h4040_0000, 4'd2, 32'h4040_0000},
         '{1'b0, 4'd3, 32'h4200_0000, 4'd2, 32'h4040_0000},
         '{1'b1, 4'd4, 32'h3F00_0000, 4'd2, 32'h4040_0000}
      };
      // reset held with random activity on every input
      repeat (3) begin
         tick();
         cmp_start = 1'($urandom);
         cmp_data = $urandom;
         cmp_index_in = 4'($urandom);
         in1 = 8'($urandom); in2 = 8'($urandom); in3 = 8'($urandom); in4 = 8'($urandom);
         expect_reset();
      end
      tick();
      cmp_start = 1'b0;
      reset_n = 1'b1;
      expect_reset();
      // divider: rise at edge 4, period 8
      for (int k = 1; k <= 21; k++) begin
         tick();
         expect_v(0, (k / 4) % 2, 0);
      end
      tick();
      reset_n = 1'b0;
      expect_reset();
      tick();
      expect_reset();
      tick();
      reset_n = 1'b1;
      expect_v(0, 32'h0, 0);
      for (int k = 1; k <= 40; k++) begin
         tick();
         expect_v(0, (k / 4) % 2, 0);
      end
      // display
      disp(8'h3A, 8'hF0, 8'h96, 8'hA5, 48'h88_B0_C0_8E_82_90);
      disp(8'hE7, 8'hD1, 8'h4B, 8'h3C, 48'hF8_86_F9_A1_83_99);
      settle();
      // argmax
      foreach (pos_v[i]) cmp(pos_v[i]);
      settle();
      foreach (neg_v[i]) cmp(neg_v[i]);
      settle();
      cmp('{1'b1, 4'd0, 32'h7FC0_0000, 4'd0, 32'h7FC0_0000});
      cmp('{1'b1, 4'd1, 32'h3F80_0000, 4'd0, 32'h7FC0_0000});
      settle();
      foreach (gate_v[i]) cmp(gate_v[i]);
      settle();
      tick();
      reset_n = 1'b0;
      expect_reset();
      tick();
      reset_n = 1'b1;
      cmp('{1'b1, 4'd0, 32'h3F80_0000, 4'd0, 32'h3F80_0000});
      settle();
      // drain the scoreboard with a bounded wait
      for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
      #1;
      if (q.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain pending=%0d expected=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/clkdiv_display_compare.md
# clkdiv_display_compare

Board-level utility block for the MLP inference top level. It combines three functions:
- a programmable clock-enable divider that produces a slow square wave (1 Hz at 50 MHz by default), which drives the periodic inference start;
- a streaming IEEE-754 single-precision argmax comparator that tracks the index of the largest output-neuron score;
- a seven-segment/LED status driver for the DE10-Lite HEX displays.

All logic runs in one clock domain.

## Interface
Parameters:
- HALF_PERIOD, default 25_000_000: number of clk cycles per half-period of clk_out; must be ≥ 1.
- IDX_W, default 4: width of the comparator index.

Ports:
- clk  input  1  system clock (50 MHz).
- reset_n  input  1  reset; asynchronous, active-low.
- clk_out  output  1  divided square wave.
- cmp_start  input  1  one-cycle sample strobe; presents one score to the comparator.
- cmp_data  input  32  IEEE-754 fp32 score.
- cmp_index_in  input  IDX_W  index of the score presented on cmp_data.
- cmp_index_out  output  IDX_W  index of the running maximum.
- cmp_max  output  32  value of the running maximum.
- in1, in2, in3, in4  input  8 each  display operands.
- seg1..seg6  output  8 each  HEX0..HEX5 segments, active-low; bit7 = decimal point, bits6:0 = g..a.
- ledr  output  8  LED bar (LEDR[7:0]), active-high.

## Operation
Divider:
- Holds a counter that runs from 0 to HALF_PERIOD-1.
- When the counter equals HALF_PERIOD-1, the counter returns to 0 and clk_out toggles.
- Full output period is 2·HALF_PERIOD cycles with a 50 % duty cycle.

Comparator:
- Acts only on clock edges where cmp_start=1. All other cycles hold state.
- If cmp_index_in == 0, it loads unconditionally: max ← cmp_data, idx ← 0. This load happens even if cmp_data is NaN.
- Otherwise, if gt(cmp_data, max), then max ← cmp_data and idx ← cmp_index_in.
- Ties are not updates, so the earlier index wins. +0 and −0 are equal.
- gt(a, b) is evaluated as follows:
  - It is false if either operand is NaN (exponent all ones and mantissa ≠ 0).
  - Signs differ: true if a is positive, unless both operands are zero.
  - Both positive: compare a[30:0] > b[30:0] unsigned.
  - Both negative: compare a[30:0] < b[30:0] unsigned.
  - ±Inf is handled by the same rules.
- cmp_max and cmp_index_out are driven directly from the registers.

Display:
- Each hex nibble is encoded as active-low segments with bit7 = 1 (decimal point off):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
- Nibble-to-digit mapping:
  - seg1 ← in1[3:0], seg2 ← in1[7:4]
  - seg3 ← in2[3:0], seg4 ← in2[7:4]
  - seg5 ← in3[3:0], seg6 ← in3[7:4]
- ledr ← in4.
- All display outputs are registered.

## Timing
Reset values (asserted immediately on reset_n=0, independent of clk):
- Divider: counter=0, clk_out=0.
- Comparator: max=32'hFF80_0000 (−Inf), cmp_index_out=0.
- Display: seg1..seg6 = 8'hFF (blank), ledr = 8'h00.

Divider:
- The first clk_out rise occurs on the HALF_PERIOD-th rising clk edge after reset_n deasserts.
- Every subsequent toggle follows HALF_PERIOD edges later.

Comparator:
- Latency is 1 cycle: the new max and index are visible the cycle after the cmp_start edge.
- Back-to-back strobes on consecutive cycles must each be evaluated against the value updated by the previous strobe.

Display:
- Latency is 1 cycle from an input change to a seg/ledr change.

Reset mid-operation:
- All state returns to the reset values above.
- After release, the divider restarts its count from 0.
- The comparator's running max is lost; the next index-0 sample reloads it.

## Test plan
- Reset/idle: hold reset_n=0 with random inputs → clk_out=0, cmp_max=FF800000, cmp_index_out=0, all seg=FF, ledr=00. Release → values hold until the first clk edge that acts on them.
- Divider with HALF_PERIOD=4: run 40 cycles after release → clk_out rises at edge 4, falls at edge 8, period exactly 8 cycles, 5 full periods. Assert reset_n=0 at edge 22 → clk_out=0 immediately; after release, the next rise comes 4 edges later.
- Display: in1=3A, in2=F0, in3=96, in4=A5 → next cycle seg1=88, seg2=B0, seg3=C0, seg4=8E, seg5=82, seg6=90, ledr=A5.
- Argmax, positive scores: stream indices 0..9 with one strobe per cycle, values 1.0 (3F800000), 2.5 (40200000), 0.5, 2.5, 7.0 (40E00000), 3.0, … → cmp_index_out=4, cmp_max=40E00000. The tie at index 3 does not update.
- Argmax, negative/zero/NaN: index 0 = −3.0 (C0400000), 1 = −1.0 (BF800000), 2 = NaN (7FC00000), 3 = −0.0 (80000000), 4 = +0.0 → final idx=3, max=80000000. A new index-0 strobe with −5.0 → idx=0, max=C0A00000.
- Strobe gating: pulse cmp_start only on alternate cycles while cmp_data changes every cycle → only the strobed samples affect the result. A reset between two samples clears the result to −Inf/0.
